// File: rtl/cl_pairhmm_package.sv
// Shared PairHMM result-record types and write-back line geometry constants.
// Records are packed MSB-first so that the id field lands in bits [31:0].
package cl_pairhmm_package;

  localparam int RESULT_RECORD_WIDTH = 192;
  localparam int RESULT_SLOT_WIDTH   = 256;
  localparam int WB_LINE_BYTES       = 64;
  localparam int WB_LINE_WIDTH       = WB_LINE_BYTES * 8;

  typedef struct packed {
    logic [31:0] deletion;
    logic [31:0] insertion;
    logic [31:0] match;
    logic [31:0] tb;
    logic [31:0] ta;
    logic [31:0] id;
  } result_record_t;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_FILL,
    WB_SEND
  } wb_state_t;

  function automatic logic [RESULT_SLOT_WIDTH-1:0] record_to_slot(input result_record_t rec);
    return {{(RESULT_SLOT_WIDTH - RESULT_RECORD_WIDTH){1'b0}}, rec};
  endfunction

endpackage

// File: rtl/cl_result_writeback_packer.sv
// Packs two 192-bit result records into one 64-byte ring-buffer line; wr_valid_o rises the cycle after the
// completing accept or flush/timeout. While a line waits on wr_ready_i no record is accepted.
module cl_result_writeback_packer
  import cl_pairhmm_package::*;
#(
  parameter int BUF_LINES     = 1024,
  parameter int FLUSH_TIMEOUT = 256
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           enable_i,
  input  logic                           flush_i,
  input  logic [63:0]                    base_addr_i,
  input  logic                           result_valid_i,
  input  logic [RESULT_RECORD_WIDTH-1:0] result_data_i,
  output logic                           result_ready_o,
  output logic                           wr_valid_o,
  input  logic                           wr_ready_i,
  output logic [63:0]                    wr_addr_o,
  output logic [WB_LINE_WIDTH-1:0]       wr_data_o,
  output logic [WB_LINE_BYTES-1:0]       wr_strb_o,
  output logic [31:0]                    lines_written_o
);

  localparam int IDX_W      = $clog2(BUF_LINES);
  localparam int CNT_W      = $clog2(FLUSH_TIMEOUT + 1);
  localparam int LINE_SHIFT = $clog2(WB_LINE_BYTES);

  wb_state_t                      state;
  logic [IDX_W-1:0]               line_idx;
  logic [CNT_W-1:0]               idle_cnt;
  logic                           accept;
  logic                           timeout_hit;
  result_record_t                 rec_in;
  logic [RESULT_SLOT_WIDTH-1:0]   slot_in;
  logic [63:0]                    line_addr;

  assign result_ready_o = enable_i && (state != WB_SEND) && !reset_i;
  assign accept         = result_valid_i && result_ready_o;
  assign rec_in         = result_record_t'(result_data_i);
  assign slot_in        = record_to_slot(rec_in);
  assign timeout_hit    = (idle_cnt == CNT_W'(FLUSH_TIMEOUT - 1));

  // BUF_LINES is a power of two, so the natural index rollover is the ring wrap.
  assign line_addr = base_addr_i
                   + {{(64 - IDX_W - LINE_SHIFT){1'b0}}, line_idx, {LINE_SHIFT{1'b0}}};

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state           <= WB_IDLE;
      wr_valid_o      <= 1'b0;
      wr_data_o       <= '0;
      wr_strb_o       <= '0;
      wr_addr_o       <= '0;
      line_idx        <= '0;
      idle_cnt        <= '0;
      lines_written_o <= '0;
    end else begin
      case (state)
        WB_IDLE: begin
          if (accept) begin
            // Clearing slot1 here makes a later half-line flush carry zeros there.
            wr_data_o <= {{RESULT_SLOT_WIDTH{1'b0}}, slot_in};
            idle_cnt  <= '0;
            state     <= WB_FILL;
          end
        end

        WB_FILL: begin
          if (accept) begin
            wr_data_o[WB_LINE_WIDTH-1:RESULT_SLOT_WIDTH] <= slot_in;
            wr_strb_o  <= '1;
            wr_addr_o  <= line_addr;
            wr_valid_o <= 1'b1;
            idle_cnt   <= '0;
            state      <= WB_SEND;
          end else if (flush_i || timeout_hit) begin
            wr_strb_o  <= {{(WB_LINE_BYTES / 2){1'b0}}, {(WB_LINE_BYTES / 2){1'b1}}};
            wr_addr_o  <= line_addr;
            wr_valid_o <= 1'b1;
            idle_cnt   <= '0;
            state      <= WB_SEND;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        WB_SEND: begin
          if (wr_ready_i) begin
            wr_valid_o      <= 1'b0;
            line_idx        <= line_idx + 1'b1;
            lines_written_o <= lines_written_o + 32'd1;
            state           <= WB_IDLE;
          end
        end

        default: state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cl_result_writeback_packer.sv
// Bench for cl_result_writeback_packer: vector table, directed corner sequences and a
// randomized run against a queue-based line-assembly model.
module tb_cl_result_writeback_packer;

  localparam int TB_BUF = 4;
  localparam int TB_TO  = 16;

  logic         clock;
  logic         reset;
  logic         enable;
  logic         flush;
  logic [63:0]  base_addr;
  logic         result_valid;
  logic [191:0] result_data;
  logic         result_ready;
  logic         wr_valid;
  logic         wr_ready;
  logic [63:0]  wr_addr;
  logic [511:0] wr_data;
  logic [63:0]  wr_strb;
  logic [31:0]  lines_written;

  int errors = 0;
  int checks = 0;

  cl_result_writeback_packer #(.BUF_LINES(TB_BUF), .FLUSH_TIMEOUT(TB_TO)) dut (
    .clock_i(clock), .reset_i(reset), .enable_i(enable), .flush_i(flush),
    .base_addr_i(base_addr), .result_valid_i(result_valid), .result_data_i(result_data),
    .result_ready_o(result_ready), .wr_valid_o(wr_valid), .wr_ready_i(wr_ready),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_strb_o(wr_strb),
    .lines_written_o(lines_written)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] HALF_STRB = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] FULL_STRB = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s: got %b expected %b", name, act, exp); end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s: got %h expected %h", name, act, exp); end
  endtask

  task automatic chkd(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s: got %h expected %h", name, act, exp); end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired, got no event expected one", name);
  endtask

  function automatic logic [191:0] mkrec(input logic [31:0] id);
    return {32'hDE1E_0000 ^ id, 32'h1D5E_0000 ^ id, 32'hAA00_0000 ^ id,
            32'h7B00_0000 ^ id, 32'h7A00_0000 ^ id, id};
  endfunction

  function automatic logic [255:0] slot(input logic [191:0] r);
    return {64'b0, r};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_rec(input logic [191:0] r, input logic f);
    int n = 0;
    result_valid = 1'b1;
    result_data  = r;
    flush        = f;
    #1;
    while (!result_ready && n < 100) begin
      tick();
      #1;
      n++;
    end
    if (n >= 100) fail_now("send_rec_ready");
    tick();
    result_valid = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic wait_line(output logic ok);
    int n = 0;
    while (!wr_valid && n < 64) begin
      tick();
      n++;
    end
    ok = wr_valid;
    if (!ok) fail_now("wait_line");
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; flush = 1'b0; result_valid = 1'b0; wr_ready = 1'b1;
    tick();
    tick();
    chk1("reset_ready", result_ready, 1'b0);
    chk1("reset_wr_valid", wr_valid, 1'b0);
    chkd("reset_wr_data", wr_data, '0);
    chk64("reset_wr_strb", wr_strb, '0);
    chk64("reset_wr_addr", wr_addr, '0);
    chk64("reset_lines", 64'(lines_written), 64'd0);
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic [31:0] id_a;
    logic [31:0] id_b;
    logic        two;
    logic        flush_b;
    logic [63:0] exp_addr;
    logic [63:0] exp_strb;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [6];

  // Random-phase model state
  logic [191:0] held_q[$];
  logic         pend;
  logic [511:0] e_data;
  logic [63:0]  e_strb;
  logic [63:0]  e_addr;
  int           idle;
  int unsigned  m_lines;
  int           m_idx;

  initial begin
    logic ok;
    int   cnt;

    vecs[0] = '{32'd1,  32'd2,  1'b1, 1'b0, 64'h1000, FULL_STRB, 32'd1};
    vecs[1] = '{32'd3,  32'd0,  1'b0, 1'b0, 64'h1040, HALF_STRB, 32'd2};
    vecs[2] = '{32'd4,  32'd5,  1'b1, 1'b1, 64'h1080, FULL_STRB, 32'd3};
    vecs[3] = '{32'd6,  32'd0,  1'b0, 1'b0, 64'h10C0, HALF_STRB, 32'd4};
    vecs[4] = '{32'd8,  32'd9,  1'b1, 1'b0, 64'h1000, FULL_STRB, 32'd5};
    vecs[5] = '{32'd10, 32'd11, 1'b1, 1'b1, 64'h1040, FULL_STRB, 32'd6};

    reset = 1'b1; enable = 1'b0; flush = 1'b0; base_addr = 64'h1000;
    result_valid = 1'b0; result_data = '0; wr_ready = 1'b1;
    do_reset();

    // Table: single lines, full or flushed half, incl. flush coincident with second accept.
    for (int i = 0; i < 6; i++) begin
      send_rec(mkrec(vecs[i].id_a), 1'b0);
      if (vecs[i].two) send_rec(mkrec(vecs[i].id_b), vecs[i].flush_b);
      else begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
      wait_line(ok);
      if (ok) begin
        chk64($sformatf("vec%0d_addr", i), wr_addr, vecs[i].exp_addr);
        chk64($sformatf("vec%0d_strb", i), wr_strb, vecs[i].exp_strb);
        chkd($sformatf("vec%0d_data", i), wr_data,
             vecs[i].two ? {slot(mkrec(vecs[i].id_b)), slot(mkrec(vecs[i].id_a))}
                         : {256'b0, slot(mkrec(vecs[i].id_a))});
      end
      tick();
      chk64($sformatf("vec%0d_lines", i), 64'(lines_written), 64'(vecs[i].exp_cnt));
      chk1($sformatf("vec%0d_idle", i), wr_valid, 1'b0);
    end

    // Ten full lines around a four-line ring.
    do_reset();
    base_addr = 64'h2000;
    for (int i = 0; i < 10; i++) begin
      send_rec(mkrec(32'(100 + 2 * i)), 1'b0);
      send_rec(mkrec(32'(101 + 2 * i)), 1'b0);
      wait_line(ok);
      if (ok) chk64($sformatf("ring%0d_addr", i), wr_addr, 64'h2000 + 64'(i % TB_BUF) * 64'd64);
      tick();
    end
    chk64("ring_lines", 64'(lines_written), 64'd10);

    // Sink stalls for 20 cycles while a further record waits.
    wr_ready = 1'b0;
    send_rec(mkrec(32'd20), 1'b0);
    send_rec(mkrec(32'd21), 1'b0);
    result_valid = 1'b1;
    result_data  = mkrec(32'd22);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk1("stall_ready", result_ready, 1'b0);
      chk1("stall_valid", wr_valid, 1'b1);
      chk64("stall_addr", wr_addr, 64'h2080);
      chk64("stall_strb", wr_strb, FULL_STRB);
      chkd("stall_data", wr_data, {slot(mkrec(32'd21)), slot(mkrec(32'd20))});
      tick();
    end
    wr_ready = 1'b1;
    send_rec(mkrec(32'd22), 1'b0);
    send_rec(mkrec(32'd23), 1'b0);
    wait_line(ok);
    if (ok) begin
      chk64("after_stall_addr", wr_addr, 64'h20C0);
      chkd("after_stall_data", wr_data, {slot(mkrec(32'd23)), slot(mkrec(32'd22))});
    end
    tick();
    chk64("after_stall_lines", 64'(lines_written), 64'd12);

    // Reset while one record is held: it must vanish.
    send_rec(mkrec(32'd30), 1'b0);
    tick();
    tick();
    do_reset();
    cnt = 0;
    for (int i = 0; i < 2 * TB_TO; i++) begin
      if (wr_valid) cnt++;
      tick();
    end
    chk64("no_line_after_reset", 64'(cnt), 64'd0);
    base_addr = 64'h3000;
    send_rec(mkrec(32'd31), 1'b0);
    send_rec(mkrec(32'd32), 1'b0);
    wait_line(ok);
    if (ok) begin
      chk64("post_reset_addr", wr_addr, 64'h3000);
      chkd("post_reset_data", wr_data, {slot(mkrec(32'd32)), slot(mkrec(32'd31))});
    end
    tick();
    chk64("post_reset_lines", 64'(lines_written), 64'd1);

    // Timeout: lone record goes out exactly TB_TO cycles after acceptance.
    send_rec(mkrec(32'd7), 1'b0);
    cnt = 0;
    for (int i = 1; i < TB_TO; i++) begin
      tick();
      if (wr_valid) cnt++;
    end
    chk64("timeout_not_early", 64'(cnt), 64'd0);
    tick();
    chk1("timeout_valid", wr_valid, 1'b1);
    chk64("timeout_strb", wr_strb, HALF_STRB);
    chk64("timeout_addr", wr_addr, 64'h3040);
    chkd("timeout_data", wr_data, {256'b0, slot(mkrec(32'd7))});
    tick();

    // Flush while idle does nothing.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    chk1("idle_flush_ignored", wr_valid, 1'b0);

    // Randomized run against the line-assembly model.
    do_reset();
    base_addr = 64'h4000;
    held_q.delete();
    pend = 1'b0; idle = 0; m_lines = 0; m_idx = 0;
    e_data = '0; e_strb = '0; e_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      enable       = ($urandom_range(0, 9) != 0);
      result_valid = ($urandom_range(0, 9) < 6);
      result_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      flush        = ($urandom_range(0, 19) == 0);
      wr_ready     = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) == 0) base_addr = {$urandom, $urandom} & ~64'h3F;
      #1;
      chk1("rnd_ready", result_ready, enable && !pend);
      chk1("rnd_valid", wr_valid, pend);
      chk64("rnd_lines", 64'(lines_written), 64'(m_lines));
      if (pend) begin
        chk64("rnd_addr", wr_addr, e_addr);
        chk64("rnd_strb", wr_strb, e_strb);
        chkd("rnd_data", wr_data, e_data);
      end
      if (pend) begin
        if (wr_ready) begin
          pend = 1'b0;
          m_lines++;
          m_idx = (m_idx + 1) % TB_BUF;
        end
      end else if (result_valid && enable) begin
        held_q.push_back(result_data);
        idle = 0;
        if (held_q.size() == 2) begin
          e_data = {64'b0, held_q[1], 64'b0, held_q[0]};
          e_strb = FULL_STRB;
          e_addr = base_addr + 64'(m_idx) * 64'd64;
          pend   = 1'b1;
          held_q.delete();
        end
      end else if (held_q.size() == 1) begin
        if (flush || idle + 1 == TB_TO) begin
          e_data = {256'b0, 64'b0, held_q[0]};
          e_strb = HALF_STRB;
          e_addr = base_addr + 64'(m_idx) * 64'd64;
          pend   = 1'b1;
          idle   = 0;
          held_q.delete();
        end else begin
          idle++;
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
